// File: rtl/ext_bus_pkg.sv
// Shared types and constants for the two-master external bus arbiter.
// Imported by ext_bus_arb; rr_pick2 needs none of it.
package ext_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 10;
    localparam logic [DATA_W-1:0] ERR_DATA = 10'h3FF;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef struct packed {
        logic              re;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin pick; on a tie the requester
// that did not win last time gets the grant.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       valid
);

    always_comb begin
        gnt = 1'b0;
        unique case (req)
            2'b11:   gnt = ~last;
            2'b10:   gnt = 1'b1;
            default: gnt = 1'b0;
        endcase
    end

    assign valid = |req;

endmodule

// File: rtl/ext_bus_arb.sv
// Two-master arbiter/sequencer for the external slave port, with
// per-transaction s_rdy handshake and a timeout against hung slaves.
module ext_bus_arb #(
    parameter int ADDR_W = ext_bus_pkg::ADDR_W,
    parameter int DATA_W = ext_bus_pkg::DATA_W,
    parameter int TIMEOUT = 15,
    parameter logic [DATA_W-1:0] ERR_DATA = ext_bus_pkg::ERR_DATA
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_re,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_re,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              m_err,
    output logic              s_re,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_rdy,
    output logic              grant,
    output logic              busy
);

    import ext_bus_pkg::*;

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t            state;
    state_t            state_n;
    bus_req_t          cur;
    bus_req_t          nxt;
    logic              gnt_q;
    logic              last_q;
    logic              err_q;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              pick;
    logic              pick_ok;
    logic              at_last;

    rr_pick2 u_pick (
        .req   ({m1_re | m1_we, m0_re | m0_we}),
        .last  (last_q),
        .gnt   (pick),
        .valid (pick_ok)
    );

    assign at_last = (cnt == LAST);

    // Write wins when a master raises both strobes.
    always_comb begin
        nxt = '0;
        if (pick) begin
            nxt.re    = m1_re & ~m1_we;
            nxt.we    = m1_we;
            nxt.addr  = m1_addr;
            nxt.wdata = m1_wdata;
        end else begin
            nxt.re    = m0_re & ~m0_we;
            nxt.we    = m0_we;
            nxt.addr  = m0_addr;
            nxt.wdata = m0_wdata;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (pick_ok) state_n = ACCESS;
            ACCESS:  if (s_rdy || at_last) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cur    <= '0;
            gnt_q  <= 1'b0;
            last_q <= 1'b1;
            err_q  <= 1'b0;
            cnt    <= '0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (pick_ok) begin
                        cur    <= nxt;
                        gnt_q  <= pick;
                        last_q <= pick;
                        cnt    <= '0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    // s_rdy in the last allowed cycle still completes normally.
                    if (s_rdy || at_last) begin
                        err_q <= ~s_rdy;
                        if (cur.re && !gnt_q)
                            rdata0 <= s_rdy ? s_rdata : ERR_DATA;
                        if (cur.re && gnt_q)
                            rdata1 <= s_rdy ? s_rdata : ERR_DATA;
                    end
                end
                RESP:    cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

    assign m0_rdata = rdata0;
    assign m1_rdata = rdata1;
    assign m0_ack   = (state == RESP) & ~gnt_q;
    assign m1_ack   = (state == RESP) & gnt_q;
    assign m_err    = (state == RESP) & err_q;
    assign s_re     = (state == ACCESS) & cur.re;
    assign s_we     = (state == ACCESS) & cur.we;
    assign s_addr   = cur.addr;
    assign s_wdata  = cur.wdata;
    assign grant    = gnt_q;
    assign busy     = (state != IDLE);

endmodule

// File: doc/ext_bus_arb.md
Name: ext_bus_arb

Overview:
Two-master arbiter and sequencer for the 16-bit-address / 10-bit-data external bus driven by `cpu` (ex_re/ex_we/addr/wdata/rdata). It shares a single external slave port between the CPU (master 0) and a debug/DMA loader (master 1). Each transaction is handshaken with a slave ready signal, and a timeout guards against a hung slave. The block sits between `cpu` and the memory-mapped I/O / switch-LED decode.

Parameters:
ADDR_W, 16, address width
DATA_W, 10, data width
TIMEOUT, 15, max ACCESS cycles waiting for s_rdy before forced error completion (>=1)
ERR_DATA, 10'h3FF, rdata returned on timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
m0_re  in  1  CPU read request (level; held until m0_ack)
m0_we  in  1  CPU write request (level; held until m0_ack)
m0_addr  in  ADDR_W  CPU address
m0_wdata  in  DATA_W  CPU write data
m0_rdata  out  DATA_W  CPU read data; valid while m0_ack=1
m0_ack  out  1  one-cycle completion pulse to CPU
m1_re, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack  (same directions/widths)  master 1 equivalents
m_err  out  1  valid with either ack; 1 = timed out
s_re  out  1  slave read strobe
s_we  out  1  slave write strobe
s_addr  out  ADDR_W  slave address
s_wdata  out  DATA_W  slave write data
s_rdata  in  DATA_W  slave read data; sampled when s_rdy=1
s_rdy  in  1  slave done; may be high in the first ACCESS cycle (zero wait)
grant  out  1  index of the master owning the bus (valid when busy=1)
busy  out  1  1 in ACCESS or RESP

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0. last_grant=1, so master 0 wins the first tie. Timeout counter=0. Any in-flight access is abandoned with no ack.
- States:
  - IDLE: sample m0_req=(m0_re|m0_we) and m1_req. Neither asserted: stay. One asserted: grant it. Both asserted: grant ~last_grant (round robin). On grant, latch addr, wdata, and op (we has priority if re&we are both high) into registers, set last_grant, go to ACCESS.
  - ACCESS: s_re/s_we/s_addr/s_wdata driven from the latched registers. Counter increments each cycle.
    - s_rdy=1: capture s_rdata (reads only) into the granted master's rdata register; err=0; go to RESP.
    - Counter reaches TIMEOUT-1 with s_rdy=0: rdata=ERR_DATA (reads), err=1, go to RESP. s_rdy in that same cycle wins over the timeout.
  - RESP: granted mN_ack=1 for exactly one cycle; m_err valid. s_re/s_we=0. Counter cleared. Return to IDLE.
- Latency: a request sampled at edge k → ACCESS cycle k+1 → with zero wait, ack in cycle k+2 → IDLE cycle k+3. Minimum 3 cycles per transaction; no back-to-back overlap.
- Master protocol: the master drops its request on the edge at which it sees ack. A request still high in the following IDLE is treated as a new transaction.
- Request changes during ACCESS are ignored, because transaction fields are latched.
- The ungranted master's ack stays 0. Its rdata holds its last value.
- s_re and s_we are never both 1. Slave strobes are 0 outside ACCESS.

Decomposition:
- Package ext_bus_pkg holds:
  - state enum {IDLE, ACCESS, RESP}
  - ADDR_W/DATA_W defaults
  - ERR_DATA constant
  - packed struct bus_req_t {re, we, addr, wdata}
- One sub-module, rr_pick2: combinational two-requester round-robin pick (req[1:0], last → gnt, valid), reused by future I/O arbiters.

Test Plan:
- CPU read, zero wait: m0_re=1, m0_addr=16'h00F0, s_rdy tied 1, s_rdata=10'b1010101010 → s_re high 1 cycle with s_addr=16'h00F0; m0_ack pulse 2 cycles after request with m0_rdata=10'h2AA, m_err=0.
- Write with 3 wait states: m1_we=1, addr=16'h0010, wdata=10'h155, s_rdy high on the 4th ACCESS cycle → s_we held 4 cycles with s_wdata=10'h155; m1_ack pulse next cycle; m0_ack stays 0.
- Simultaneous requests held continuously for 4 transactions after reset → grant sequence 0,1,0,1; each ack only to the granted master.
- Timeout: m0_re=1, s_rdy=0 forever, TIMEOUT=15 → s_re high exactly 15 cycles; m0_ack with m_err=1 and m0_rdata=10'h3FF.
- s_rdy rises in the final timeout cycle → normal completion: m_err=0, captured s_rdata returned.
- Reset mid-ACCESS: assert rst_n=0 during a waited read → all outputs 0 asynchronously, no ack. After release with both masters requesting, master 0 is granted first.
